// File: rtl/mult_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : mult_operand_stage
// Brief    : Handshaked operand/result stage around a combinational array
//            multiplier. Registers an operand pair onto the multiplier
//            inputs, waits a programmable settle time, captures the product
//            and offers it downstream. Counts delivered results.
// Revision : 1.0 - initial release
// ============================================================================
module mult_operand_stage #(
    parameter int SIZE     = 16,
    parameter int RES_SIZE = 32,
    parameter int SETTLE   = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iValid,
    output logic                oReady,
    input  logic [SIZE-1:0]     iA,
    input  logic [SIZE-1:0]     iB,
    output logic [SIZE-1:0]     oMulA,
    output logic [SIZE-1:0]     oMulB,
    input  logic [RES_SIZE-1:0] iMulRes,
    output logic                oValid,
    input  logic                iReady,
    output logic [RES_SIZE-1:0] oResult,
    output logic [15:0]         oCount
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Counter is loaded with SETTLE-1 so capture lands exactly SETTLE edges
    // after the accept edge.
    localparam logic [3:0] c_settle_init = 4'(SETTLE - 1);

    state_t              state_q,  state_d;
    logic [3:0]          cnt_q,    cnt_d;
    logic [SIZE-1:0]     mul_a_q,  mul_a_d;
    logic [SIZE-1:0]     mul_b_q,  mul_b_d;
    logic [RES_SIZE-1:0] result_q, result_d;
    logic                valid_q,  valid_d;
    logic [15:0]         count_q,  count_d;

    logic                accept;
    logic                out_hs;

    // Ready: free in IDLE, free in HOLD only when the held result is being
    // taken this edge; forced low while reset is asserted.
    always_comb begin
        oReady = 1'b0;
        if (Reset) begin
            case (state_q)
                ST_IDLE: oReady = 1'b1;
                ST_HOLD: oReady = iReady;
                default: oReady = 1'b0;
            endcase
        end
    end

    assign accept = iValid & oReady;
    assign out_hs = valid_q & iReady;

    // Next-state and datapath update for the accept / settle / hold sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        result_d = result_q;
        valid_d  = valid_q;
        count_d  = count_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mul_a_d = iA;
                    mul_b_d = iB;
                    cnt_d   = c_settle_init;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    result_d = iMulRes;
                    valid_d  = 1'b1;
                    state_d  = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (out_hs) begin
                    count_d = count_q + 16'd1;
                    valid_d = 1'b0;
                    if (accept) begin
                        mul_a_d = iA;
                        mul_b_d = iB;
                        cnt_d   = c_settle_init;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign oMulA   = mul_a_q;
    assign oMulB   = mul_b_q;
    assign oResult = result_q;
    assign oValid  = valid_q;
    assign oCount  = count_q;

endmodule
`default_nettype wire
